fifo_x10_rd_drain: RTL and testbench

Read-side drain controller for the 10-lane, 18-bit-per-digit RNS FIFO bank; runs in the read clock domain directly downstream of the bank. It issues a single shared read request only when all ten lanes are non-empty, captures the ten digits one cycle later into a small skid buffer, and presents them as one 180-bit valid/ready word to the TPU matrix stage. It also watches the ten empty flags for lane skew and halts reads on persistent disagreement.

---
 rtl/fifo_x10_rd_drain.sv | 162 ++++++++++++++++
 tb/tb_fifo_x10_rd_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_x10_rd_drain.sv
// Read-side drain controller for the 10-lane RNS FIFO bank.
// Issues one shared read when every lane holds data and lands the digits in a
// small skid buffer. It presents the buffer head as a 180-bit valid/ready word
// and halts reading when the lane empty flags disagree for too long.
module fifo_x10_rd_drain #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SKEW_LIMIT = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [9:0]       rd_empty_,
  input  logic [179:0]     fifo_q_,
  output logic             rd_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [179:0]     dig_out,
  input  logic             clr_err,
  output logic             skew_err,
  output logic             halted,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_C = (OCC_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);
  localparam logic [7:0]       LIMIT_C = 8'(SKEW_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SKEW,
    ST_HALT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_skew_cnt;
  logic [7:0]         w_skew_cnt_nxt;
  logic               r_skew_err;
  logic               w_skew_err_nxt;
  logic [OCC_W-1:0]   r_occ;
  logic               r_inflight;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [179:0]       r_buf [DEPTH];

  logic               w_all_ready;
  logic               w_mismatch;
  logic [OCC_W:0]     w_fill;
  logic               w_room;
  logic               w_push;
  logic               w_pop;

  assign w_all_ready = (rd_empty_ == '0);
  assign w_mismatch  = !w_all_ready && (rd_empty_ != '1);

  // Reserve a slot for the word already in flight so the buffer never overflows.
  assign w_fill = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_room = (w_fill < DEPTH_C);

  assign rd_req    = (r_state != ST_HALT) && w_all_ready && w_room;
  assign out_valid = (r_occ != '0);
  assign dig_out   = out_valid ? r_buf[r_head] : '0;
  assign skew_err  = r_skew_err;
  assign halted    = (r_state == ST_HALT);
  assign word_cnt  = r_word_cnt;

  assign w_push = r_inflight;
  assign w_pop  = out_valid && out_ready;

  // Skew FSM: next-state, skew counter and sticky error.
  always_comb begin
    w_state_nxt    = r_state;
    w_skew_cnt_nxt = r_skew_cnt;
    w_skew_err_nxt = r_skew_err;
    case (r_state)
      ST_RUN: begin
        if (w_mismatch) begin
          w_skew_cnt_nxt = 8'd1;
          if (LIMIT_C == 8'd1) begin
            w_state_nxt    = ST_HALT;
            w_skew_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SKEW;
          end
        end
      end
      ST_SKEW: begin
        if (!w_mismatch) begin
          w_state_nxt    = ST_RUN;
          w_skew_cnt_nxt = '0;
        end else begin
          w_skew_cnt_nxt = r_skew_cnt + 8'd1;
          if (r_skew_cnt + 8'd1 == LIMIT_C) begin
            w_state_nxt    = ST_HALT;
            w_skew_err_nxt = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (clr_err) begin
          w_state_nxt    = ST_RUN;
          w_skew_cnt_nxt = '0;
          w_skew_err_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_skew_cnt_nxt = '0;
        w_skew_err_nxt = 1'b0;
      end
    endcase
  end

  // Skew FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_skew_cnt <= '0;
      r_skew_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_skew_cnt <= w_skew_cnt_nxt;
      r_skew_err <= w_skew_err_nxt;
    end
  end

  // Buffer bookkeeping: in-flight flag, pointers, occupancy and word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= rd_req;
      if (w_push) begin
        r_tail <= (r_tail == LAST_C) ? '0 : r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head     <= (r_head == LAST_C) ? '0 : r_head + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  // Skid-buffer storage; contents are only observed while occupancy says valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_tail] <= fifo_q_;
    end
  end

endmodule

// File: tb/tb_fifo_x10_rd_drain.sv
// Directed bench for fifo_x10_rd_drain: a behavioural 10-lane bank in normal
// read mode feeds two instances (16-bit and 4-bit word counters).
module tb_fifo_x10_rd_drain;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [9:0]    rd_empty_;
  logic [179:0]  fifo_q_;
  logic          out_ready;
  logic          clr_err;

  logic          rd_req,    rd_req4;
  logic          out_valid, out_valid4;
  logic [179:0]  dig_out,   dig_out4;
  logic          skew_err,  skew_err4;
  logic          halted,    halted4;
  logic [15:0]   word_cnt;
  logic [3:0]    word_cnt4;

  logic [17:0]   lane_q [10][$];
  logic [179:0]  exp_q [$];
  logic [9:0]    mask;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_req   = 0;
  int            req_mark;
  int            first_v;
  int            last_v;
  int            nv;
  logic          have_held;
  logic [179:0]  held;

  always #5 clk = ~clk;

  fifo_x10_rd_drain #(.DEPTH(4), .SKEW_LIMIT(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_empty_(rd_empty_), .fifo_q_(fifo_q_),
    .rd_req(rd_req), .out_valid(out_valid), .out_ready(out_ready),
    .dig_out(dig_out), .clr_err(clr_err), .skew_err(skew_err),
    .halted(halted), .word_cnt(word_cnt)
  );

  fifo_x10_rd_drain #(.DEPTH(4), .SKEW_LIMIT(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .rd_empty_(rd_empty_), .fifo_q_(fifo_q_),
    .rd_req(rd_req4), .out_valid(out_valid4), .out_ready(out_ready),
    .dig_out(dig_out4), .clr_err(clr_err), .skew_err(skew_err4),
    .halted(halted4), .word_cnt(word_cnt4)
  );

  task automatic check(input string tag, input logic [179:0] obs, input logic [179:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [179:0] make_word(input int unsigned base);
    logic [179:0] w;
    w = '0;
    for (int unsigned k = 0; k < 10; k++) w[18*k +: 18] = 18'(base + k);
    return w;
  endfunction

  task automatic upd_empty();
    for (int k = 0; k < 10; k++) rd_empty_[k] = (lane_q[k].size() == 0) || mask[k];
    #1;
  endtask

  task automatic set_mask(input logic [9:0] m);
    mask = m;
    upd_empty();
  endtask

  task automatic load_word(input int unsigned base);
    for (int unsigned k = 0; k < 10; k++) lane_q[k].push_back(18'(base + k));
    exp_q.push_back(make_word(base));
  endtask

  // One clock: score any handshake, then model the bank's registered read.
  task automatic tick();
    logic         req;
    logic [179:0] w;
    logic [179:0] e;
    req = rd_req;
    if (out_valid && out_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_underflow: observed a pop with %0d expected words", exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_data", dig_out, e);
        check("pop_data4", dig_out4, e);
      end
    end
    @(posedge clk);
    #1;
    if (req) begin
      n_req++;
      w = '0;
      for (int k = 0; k < 10; k++) w[18*k +: 18] = lane_q[k].pop_front();
      fifo_q_ = w;
    end
    upd_empty();
  endtask

  initial begin
    reset_n   = 1'b0;
    rd_empty_ = '1;
    fifo_q_   = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    mask      = '0;
    #1;
    // Reset state
    check("rst_rd_req", rd_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dig_out", dig_out, 0);
    check("rst_skew_err", skew_err, 0);
    check("rst_halted", halted, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_twin", {rd_req4, out_valid4, skew_err4, halted4, word_cnt4}, 0);
    tick(); tick();
    reset_n = 1'b1;
    #1;

    // Single word: rd_req same cycle, out_valid two cycles later
    out_ready = 1'b1;
    load_word(100);
    upd_empty();
    check("t1_rd_req", rd_req, 1);
    tick();
    check("t1_req_drop", rd_req, 0);
    check("t1_valid_lat1", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", dig_out, make_word(100));
    tick();
    check("t1_word_cnt", word_cnt, 1);
    check("t1_idle", out_valid, 0);

    // Streaming 16 words at full rate
    for (int unsigned i = 0; i < 16; i++) load_word(32'h1000 + 16 * i);
    upd_empty();
    first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 22; i++) begin
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
      tick();
    end
    check("t2_nvalid", nv, 16);
    check("t2_contig", last_v - first_v, 15);
    check("t2_first_lat", first_v, 2);
    check("t2_word_cnt", word_cnt, 17);
    check("t2_wrap_cnt4", word_cnt4, 1);

    // Backpressure: only DEPTH reads while stalled, head held steady
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 10; i++) load_word(32'h2000 + 16 * i);
    upd_empty();
    req_mark = n_req;
    have_held = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        if (have_held) check("t3_hold", dig_out, held);
        held = dig_out;
        have_held = 1'b1;
      end
      tick();
    end
    check("t3_reads", n_req - req_mark, 4);
    check("t3_rd_req_low", rd_req, 0);
    check("t3_word_cnt", word_cnt, 17);
    check("t3_head", dig_out, make_word(32'h2000));
    out_ready = 1'b1;
    first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
      tick();
    end
    check("t3_nvalid", nv, 10);
    check("t3_contig", last_v - first_v, 9);
    check("t3_word_cnt", word_cnt, 27);
    check("t3_cnt4", word_cnt4, 11);

    // Transient skew: lane 3 lags two cycles
    load_word(32'h3000);
    set_mask(10'h008);
    check("t4_req_skew0", rd_req, 0);
    tick();
    check("t4_req_skew1", rd_req, 0);
    check("t4_not_halted", halted, 0);
    tick();
    set_mask('0);
    check("t4_req_aligned", rd_req, 1);
    tick(); tick(); tick();
    check("t4_skew_err", skew_err, 0);
    check("t4_word_cnt", word_cnt, 28);

    // Persistent skew: lane 7 empty for 8 cycles halts reading
    load_word(32'h4000);
    set_mask(10'h080);
    for (int i = 0; i < 7; i++) tick();
    check("t5_pre_halt", halted, 0);
    check("t5_pre_err", skew_err, 0);
    tick();
    check("t5_halted", halted, 1);
    check("t5_skew_err", skew_err, 1);
    check("t5_halted4", halted4, 1);
    set_mask('0);
    check("t5_req_blocked", rd_req, 0);
    tick(); tick();
    check("t5_req_still_blocked", rd_req, 0);
    check("t5_still_halted", halted, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    check("t5_resumed", halted, 0);
    check("t5_err_clr", skew_err, 0);
    check("t5_req_resume", rd_req, 1);
    tick(); tick(); tick();
    check("t5_word_cnt", word_cnt, 29);

    // Reset mid-stream with two words buffered
    out_ready = 1'b0;
    load_word(32'h5000);
    load_word(32'h5010);
    upd_empty();
    tick(); tick(); tick(); tick();
    check("t6_valid_pre", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("t6_valid_rst", out_valid, 0);
    check("t6_cnt_rst", word_cnt, 0);
    check("t6_cnt4_rst", word_cnt4, 0);
    check("t6_req_rst", rd_req, 0);
    exp_q.delete();
    tick(); tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    load_word(32'h6000);
    upd_empty();
    tick(); tick(); tick();
    check("t6_cnt_after", word_cnt, 1);
    check("t6_cnt4_after", word_cnt4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
